// File: rtl/mem_arbiter_pkg.sv
// Shared constants for the memory arbiter, load/store buffer and icache:
// state encodings, access-type codes and the IO address selector.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'b00,
    ST_INST_READ  = 2'b01,
    ST_DATA_READ  = 2'b10,
    ST_DATA_WRITE = 2'b11
  } state_e;

  typedef enum logic [1:0] {
    ACC_NONE = 2'b00,
    ACC_BYTE = 2'b01,
    ACC_HALF = 2'b10,
    ACC_WORD = 2'b11
  } acc_e;

  localparam logic [1:0] IO_SEL_DEFAULT = 2'b11;

  typedef struct packed {
    logic        vld;
    acc_e        typ;
    logic        rd;
    logic [31:0] addr;
    logic [31:0] data;
  } pend_t;

  function automatic logic [2:0] acc_bytes(input acc_e t);
    case (t)
      ACC_BYTE: acc_bytes = 3'd1;
      ACC_HALF: acc_bytes = 3'd2;
      default:  acc_bytes = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the arbiter, the byte-wide RAM and its two clients
// (instruction fetch and the load/store buffer).
interface mem_arbiter_if;
  logic [7:0]  memIn;
  logic [7:0]  memOut;
  logic [31:0] memAddr;
  logic        memWr;
  logic        ioBufferFull;
  logic        instReq;
  logic [31:0] instAddr;
  logic        instValid;
  logic [31:0] instOut;
  logic [1:0]  accessType;
  logic        readWriteIn;
  logic [31:0] dataAddr;
  logic [31:0] dataIn;
  logic        dataValid;
  logic [31:0] dataOut;
  logic        dataWriteSuc;

  modport master (
    input  memIn, ioBufferFull, instReq, instAddr, accessType, readWriteIn, dataAddr, dataIn,
    output memOut, memAddr, memWr, instValid, instOut, dataValid, dataOut, dataWriteSuc
  );

  modport slave (
    output memIn, ioBufferFull, instReq, instAddr, accessType, readWriteIn, dataAddr, dataIn,
    input  memOut, memAddr, memWr, instValid, instOut, dataValid, dataOut, dataWriteSuc
  );
endinterface

// File: rtl/mem_arbiter.sv
// Byte-serial RAM arbiter: serves instruction fetches and one pending data
// access at a time, with IO-write backpressure, flush and global stall.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter logic [1:0] IO_SEL = IO_SEL_DEFAULT
) (
  input  logic          clockIn,
  input  logic          resetIn,
  input  logic          readyIn,
  input  logic          clearIn,
  mem_arbiter_if.master bus
);

  state_e      r_state;
  logic [2:0]  r_step;
  logic        r_done;
  pend_t       r_pend;
  logic [31:0] r_base;
  logic [2:0]  r_len;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;
  logic        r_io;
  logic        r_memWr;
  logic [7:0]  r_memOut;
  logic [31:0] r_memAddr;
  logic        r_instValid;
  logic [31:0] r_instOut;
  logic        r_dataValid;
  logic [31:0] r_dataOut;
  logic        r_dataWriteSuc;

  logic        w_pulse;
  logic        w_drop_rd;
  logic        w_acc_data;
  logic        w_acc_inst;
  logic        w_io_block;
  logic [7:0]  w_wbyte;

  assign w_pulse    = (bus.accessType != 2'b00);
  assign w_drop_rd  = clearIn && r_pend.vld && r_pend.rd;
  assign w_acc_data = (r_state == ST_IDLE) && r_pend.vld && !w_drop_rd;
  assign w_acc_inst = (r_state == ST_IDLE) && !r_pend.vld && bus.instReq && !clearIn;
  assign w_io_block = r_io && bus.ioBufferFull;
  assign w_wbyte    = r_wdata[{r_step[1:0], 3'b000} +: 8];

  always_ff @(posedge clockIn or negedge resetIn) begin
    if (!resetIn) begin
      r_state        <= ST_IDLE;
      r_step         <= 3'd0;
      r_done         <= 1'b0;
      r_pend         <= '0;
      r_base         <= 32'd0;
      r_len          <= 3'd0;
      r_wdata        <= 32'd0;
      r_rdata        <= 32'd0;
      r_io           <= 1'b0;
      r_memWr        <= 1'b0;
      r_memOut       <= 8'd0;
      r_memAddr      <= 32'd0;
      r_instValid    <= 1'b0;
      r_instOut      <= 32'd0;
      r_dataValid    <= 1'b0;
      r_dataOut      <= 32'd0;
      r_dataWriteSuc <= 1'b0;
    end else if (readyIn) begin
      r_memWr        <= 1'b0;
      r_memOut       <= 8'd0;
      r_instValid    <= 1'b0;
      r_instOut      <= 32'd0;
      r_dataValid    <= 1'b0;
      r_dataOut      <= 32'd0;
      r_dataWriteSuc <= 1'b0;

      // A slot leaving this edge may be refilled on the same edge; otherwise the older entry wins.
      if (w_acc_data || w_drop_rd) r_pend.vld <= 1'b0;
      if (w_pulse && (!r_pend.vld || w_acc_data || w_drop_rd) && !(clearIn && bus.readWriteIn))
        r_pend <= '{vld: 1'b1, typ: acc_e'(bus.accessType), rd: bus.readWriteIn,
                    addr: bus.dataAddr, data: bus.dataIn};

      case (r_state)
        ST_IDLE: begin
          if (w_acc_data) begin
            r_base  <= r_pend.addr;
            r_len   <= acc_bytes(r_pend.typ);
            r_wdata <= r_pend.data;
            r_rdata <= 32'd0;
            r_step  <= 3'd0;
            r_done  <= 1'b0;
            r_io    <= (r_pend.addr[17:16] == IO_SEL);
            if (r_pend.rd) begin
              r_state   <= ST_DATA_READ;
              r_memAddr <= r_pend.addr;
            end else begin
              r_state <= ST_DATA_WRITE;
            end
          end else if (w_acc_inst) begin
            r_state   <= ST_INST_READ;
            r_base    <= bus.instAddr;
            r_len     <= 3'd4;
            r_rdata   <= 32'd0;
            r_step    <= 3'd0;
            r_done    <= 1'b0;
            r_io      <= 1'b0;
            r_memAddr <= bus.instAddr;
          end
        end
        ST_INST_READ, ST_DATA_READ: begin
          if (clearIn) begin
            r_state <= ST_IDLE;
            r_step  <= 3'd0;
            r_done  <= 1'b0;
          end else if (r_step < r_len) begin
            r_rdata[{r_step[1:0], 3'b000} +: 8] <= bus.memIn;
            if ((r_step + 3'd1) < r_len) r_memAddr <= r_base + {29'd0, r_step} + 32'd1;
            r_step <= r_step + 3'd1;
          end else if (!r_done) begin
            r_done <= 1'b1;
          end else begin
            if (r_state == ST_INST_READ) begin
              r_instValid <= 1'b1;
              r_instOut   <= r_rdata;
            end else begin
              r_dataValid <= 1'b1;
              r_dataOut   <= r_rdata;
            end
            r_state <= ST_IDLE;
            r_step  <= 3'd0;
            r_done  <= 1'b0;
          end
        end
        ST_DATA_WRITE: begin
          // Writes are committed, so a flush does not interrupt them.
          if (r_step < r_len) begin
            if (!w_io_block) begin
              r_memWr   <= 1'b1;
              r_memAddr <= r_base + {29'd0, r_step};
              r_memOut  <= w_wbyte;
              r_step    <= r_step + 3'd1;
            end
          end else begin
            r_dataWriteSuc <= 1'b1;
            r_state        <= ST_IDLE;
            r_step         <= 3'd0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.memWr        = r_memWr;
  assign bus.memOut       = r_memOut;
  assign bus.memAddr      = r_memAddr;
  assign bus.instValid    = r_instValid;
  assign bus.instOut      = r_instOut;
  assign bus.dataValid    = r_dataValid;
  assign bus.dataOut      = r_dataOut;
  assign bus.dataWriteSuc = r_dataWriteSuc;

endmodule
